// File: rtl/sdram_arb_if.sv
// Bus bundle between the two requesting ports (video, CPU), the arbiter
// and the SDRAM controller command/data path. The arbiter takes the slave
// view; the environment (requesters plus controller) takes the master view.
interface sdram_arb_if;
    logic        ready;
    logic        vReq;
    logic [21:0] vA;
    logic [15:0] vQ;
    logic        vAck;
    logic        cReq;
    logic        cWr;
    logic [21:0] cA;
    logic [15:0] cD;
    logic [15:0] cQ;
    logic        cAck;
    logic        sdRd;
    logic        sdWr;
    logic        sdRfsh;
    logic [21:0] sdA;
    logic [15:0] sdD;
    logic [15:0] sdQ;

    modport slave (
        input  ready, vReq, vA, cReq, cWr, cA, cD, sdQ,
        output vQ, vAck, cQ, cAck, sdRd, sdWr, sdRfsh, sdA, sdD
    );

    modport master (
        output ready, vReq, vA, cReq, cWr, cA, cD, sdQ,
        input  vQ, vAck, cQ, cAck, sdRd, sdWr, sdRfsh, sdA, sdD
    );
endinterface

// File: rtl/sdram_arb.sv
// Two-port SDRAM access arbiter with periodic refresh insertion.
// Each granted operation owns the controller for a fixed SLOT of cycles:
// STROBE cycles of active-low command strobe, a wait until slot end where
// read data is captured, then one ACK state whose completion pulse is
// registered and visible on the cycle after it. Refresh outranks both ports;
// the ports share the remaining bandwidth round-robin.
module sdram_arb #(
    parameter int RFSH_PERIOD = 390,
    parameter int SLOT        = 12,
    parameter int STROBE      = 2
) (
    input logic        clock,
    input logic        reset,
    sdram_arb_if.slave bus
);

    localparam int CW = $clog2(SLOT);
    localparam int TW = $clog2(RFSH_PERIOD);
    localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE - 1);
    localparam logic [CW-1:0] SLOT_LAST   = CW'(SLOT - 1);
    localparam logic [TW-1:0] TIMER_LAST  = TW'(RFSH_PERIOD - 1);

    // Strobe vector bit positions: 0 = read, 1 = write, 2 = refresh.
    localparam logic [2:0] STRB_IDLE = 3'b111;
    localparam logic [2:0] STRB_RD   = 3'b110;
    localparam logic [2:0] STRB_WR   = 3'b101;
    localparam logic [2:0] STRB_RF   = 3'b011;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
    typedef enum logic [1:0] {OWN_V, OWN_C, OWN_R} owner_t;

    state_t          state_reg, state_next;
    owner_t          owner_reg;
    logic            op_wr_reg;
    logic [CW-1:0]   slot_cnt_reg;
    logic [TW-1:0]   timer_reg;
    logic            rfsh_pend_reg;
    logic            prio_cpu_reg;
    logic [2:0]      strb_reg;
    logic [2:0]      strb_out;
    logic [21:0]     sd_a_reg;
    logic [15:0]     sd_d_reg;
    logic [15:0]     v_q_reg;
    logic [15:0]     c_q_reg;
    logic            v_ack_reg;
    logic            c_ack_reg;

    logic            timer_end;
    logic            rfsh_want;
    logic            v_elig;
    logic            c_elig;
    logic            grant_v;
    logic            grant_c;
    logic            grant_r;
    logic            strobe_end;
    logic            slot_end;

    // An expiry this cycle counts as pending so it beats a same-cycle port
    // request. A port whose ack is showing right now is still holding its
    // request from the finished operation, so it is not eligible yet.
    assign timer_end = bus.ready && (timer_reg == TIMER_LAST);
    assign rfsh_want = rfsh_pend_reg || timer_end;
    assign v_elig    = bus.vReq && !v_ack_reg;
    assign c_elig    = bus.cReq && !c_ack_reg;

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state and grant decision.
    always_comb begin
        state_next = state_reg;
        grant_v    = 1'b0;
        grant_c    = 1'b0;
        grant_r    = 1'b0;
        strobe_end = 1'b0;
        slot_end   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.ready) begin
                    if (rfsh_want) begin
                        grant_r    = 1'b1;
                        state_next = ISSUE;
                    end else if (v_elig && (!c_elig || !prio_cpu_reg)) begin
                        grant_v    = 1'b1;
                        state_next = ISSUE;
                    end else if (c_elig) begin
                        grant_c    = 1'b1;
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (slot_cnt_reg == STROBE_LAST) begin
                    strobe_end = 1'b1;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (slot_cnt_reg == SLOT_LAST) begin
                    slot_end   = 1'b1;
                    state_next = ACK;
                end
            end
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: refresh timer, slot counter, latched command, captured data, acks.
    always_ff @(posedge clock) begin
        if (!reset) begin
            owner_reg     <= OWN_V;
            op_wr_reg     <= 1'b0;
            slot_cnt_reg  <= '0;
            timer_reg     <= '0;
            rfsh_pend_reg <= 1'b0;
            prio_cpu_reg  <= 1'b0;
            strb_reg      <= STRB_IDLE;
            sd_a_reg      <= '0;
            sd_d_reg      <= '0;
            v_q_reg       <= '0;
            c_q_reg       <= '0;
            v_ack_reg     <= 1'b0;
            c_ack_reg     <= 1'b0;
        end else begin
            v_ack_reg <= (state_reg == ACK) && (owner_reg == OWN_V);
            c_ack_reg <= (state_reg == ACK) && (owner_reg == OWN_C);

            if (!bus.ready || timer_end) timer_reg <= '0;
            else                         timer_reg <= timer_reg + 1'b1;

            // A second expiry while already pending is simply absorbed.
            if (!bus.ready || grant_r) rfsh_pend_reg <= 1'b0;
            else if (timer_end)        rfsh_pend_reg <= 1'b1;

            if (grant_v || grant_c || grant_r) slot_cnt_reg <= '0;
            else if (state_reg != IDLE)        slot_cnt_reg <= slot_cnt_reg + 1'b1;

            // Refresh carries no address/data, so sdA/sdD keep their last value.
            if (grant_v) begin
                owner_reg    <= OWN_V;
                op_wr_reg    <= 1'b0;
                sd_a_reg     <= bus.vA;
                strb_reg     <= STRB_RD;
                prio_cpu_reg <= 1'b1;
            end else if (grant_c) begin
                owner_reg    <= OWN_C;
                op_wr_reg    <= bus.cWr;
                sd_a_reg     <= bus.cA;
                sd_d_reg     <= bus.cD;
                strb_reg     <= bus.cWr ? STRB_WR : STRB_RD;
                prio_cpu_reg <= 1'b0;
            end else if (grant_r) begin
                owner_reg    <= OWN_R;
                op_wr_reg    <= 1'b0;
                strb_reg     <= STRB_RF;
            end else if (strobe_end) begin
                strb_reg     <= STRB_IDLE;
            end

            if (slot_end && !op_wr_reg) begin
                if (owner_reg == OWN_V) v_q_reg <= bus.sdQ;
                if (owner_reg == OWN_C) c_q_reg <= bus.sdQ;
            end
        end
    end

    // Strobes are forced inactive combinationally while reset is low so an
    // aborted command never lingers into the reset cycle.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_strb
            assign strb_out[gi] = strb_reg[gi] | ~reset;
        end
    endgenerate

    assign bus.sdRd   = strb_out[0];
    assign bus.sdWr   = strb_out[1];
    assign bus.sdRfsh = strb_out[2];
    assign bus.sdA    = sd_a_reg;
    assign bus.sdD    = sd_d_reg;
    assign bus.vQ     = v_q_reg;
    assign bus.cQ     = c_q_reg;
    assign bus.vAck   = v_ack_reg & reset;
    assign bus.cAck   = c_ack_reg & reset;

endmodule
